// File: rtl/fsm_game_pkg.sv
// Shared types for the battleship game-flow controller.
package fsm_game_pkg;

  // One encoding (3'd7) is left unused; the FSM steers it back to DECISION.
  typedef enum logic [2:0] {
    DECISION    = 3'd0,
    COLOCATION  = 3'd1,
    SETUP       = 3'd2,
    PLAYER_TURN = 3'd3,
    PC_TURN     = 3'd4,
    VICTORY     = 3'd5,
    DEFEAT      = 3'd6
  } state_t;

  localparam state_t RESET_STATE = DECISION;

endpackage

// File: rtl/fsm_game.sv
// Game-flow controller for the battleship VGA game: Moore FSM that walks
// through ship-count decision, placement, setup and alternating turns,
// ending in victory or defeat. Outputs are one-hot phase indicators.
//
// state       | meaning
// ------------+-----------------------------------------------
// DECISION    | player choosing how many ships to play with
// COLOCATION  | player placing ships on the board
// SETUP       | board and PC fleet being prepared
// PLAYER_TURN | waiting for the player's shot
// PC_TURN     | waiting for the PC's shot
// VICTORY     | all PC ships sunk; terminal until reset
// DEFEAT      | all player ships sunk; terminal until reset
module fsm_game
  import fsm_game_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ships_decided,
  input  logic finished_placing,
  input  logic finished_setUp,
  input  logic player_has_move,
  input  logic pc_ships_zero,
  input  logic pc_has_move,
  input  logic player_ships_zero,
  output logic setup_State,
  output logic decision_State,
  output logic colocation_ships_State,
  output logic player_turn_State,
  output logic pc_turn_State,
  output logic is_victory_State,
  output logic is_defeat_State
);

  state_t r_state;
  state_t w_next;

  // State register; reset is asynchronous so a mid-game reset takes effect at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RESET_STATE;
    else     r_state <= w_next;
  end

  // Next-state logic: hold by default, one transition per edge at most.
  // In the turn states, end-of-game checks win over shots, and a
  // simultaneous wipe-out of both fleets counts as a player win.
  always_comb begin
    w_next = r_state;
    case (r_state)
      DECISION:    if (ships_decided)    w_next = COLOCATION;
      COLOCATION:  if (finished_placing) w_next = SETUP;
      SETUP:       if (finished_setUp)   w_next = PLAYER_TURN;
      PLAYER_TURN: begin
        if      (pc_ships_zero)     w_next = VICTORY;
        else if (player_ships_zero) w_next = DEFEAT;
        else if (player_has_move)   w_next = PC_TURN;
      end
      PC_TURN: begin
        if      (pc_ships_zero)     w_next = VICTORY;
        else if (player_ships_zero) w_next = DEFEAT;
        else if (pc_has_move)       w_next = PLAYER_TURN;
      end
      VICTORY:     w_next = VICTORY;
      DEFEAT:      w_next = DEFEAT;
      default:     w_next = DECISION;
    endcase
  end

  // Output decode straight from the state register; the unused encoding
  // shows DECISION so the outputs stay one-hot while it recovers.
  always_comb begin
    decision_State         = 1'b0;
    colocation_ships_State = 1'b0;
    setup_State            = 1'b0;
    player_turn_State      = 1'b0;
    pc_turn_State          = 1'b0;
    is_victory_State       = 1'b0;
    is_defeat_State        = 1'b0;
    case (r_state)
      DECISION:    decision_State         = 1'b1;
      COLOCATION:  colocation_ships_State = 1'b1;
      SETUP:       setup_State            = 1'b1;
      PLAYER_TURN: player_turn_State      = 1'b1;
      PC_TURN:     pc_turn_State          = 1'b1;
      VICTORY:     is_victory_State       = 1'b1;
      DEFEAT:      is_defeat_State        = 1'b1;
      default:     decision_State         = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fsm_game.sv
// Directed testbench for the battleship game-flow controller.
module tb_fsm_game;

  logic clk;
  logic rst;
  logic ships_decided, finished_placing, finished_setUp, player_has_move;
  logic pc_ships_zero, pc_has_move, player_ships_zero;
  logic setup_State, decision_State, colocation_ships_State, player_turn_State;
  logic pc_turn_State, is_victory_State, is_defeat_State;

  int n_checks = 0;
  int n_errors = 0;

  // Output vector order: {decision, colocation, setup, player, pc, victory, defeat}
  localparam logic [6:0] O_D = 7'b1000000;
  localparam logic [6:0] O_C = 7'b0100000;
  localparam logic [6:0] O_S = 7'b0010000;
  localparam logic [6:0] O_P = 7'b0001000;
  localparam logic [6:0] O_T = 7'b0000100;
  localparam logic [6:0] O_V = 7'b0000010;
  localparam logic [6:0] O_F = 7'b0000001;

  // Flag vector order: {ships_decided, finished_placing, finished_setUp,
  //                     player_has_move, pc_has_move, pc_ships_zero, player_ships_zero}
  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_SD   = 7'b1000000;
  localparam logic [6:0] F_FP   = 7'b0100000;
  localparam logic [6:0] F_FS   = 7'b0010000;
  localparam logic [6:0] F_PHM  = 7'b0001000;
  localparam logic [6:0] F_PCM  = 7'b0000100;
  localparam logic [6:0] F_PCZ  = 7'b0000010;
  localparam logic [6:0] F_PLZ  = 7'b0000001;

  logic [6:0] outs;
  assign outs = {decision_State, colocation_ships_State, setup_State,
                 player_turn_State, pc_turn_State, is_victory_State, is_defeat_State};

  fsm_game dut (
    .clk                    (clk),
    .rst                    (rst),
    .ships_decided          (ships_decided),
    .finished_placing       (finished_placing),
    .finished_setUp         (finished_setUp),
    .player_has_move        (player_has_move),
    .pc_ships_zero          (pc_ships_zero),
    .pc_has_move            (pc_has_move),
    .player_ships_zero      (player_ships_zero),
    .setup_State            (setup_State),
    .decision_State         (decision_State),
    .colocation_ships_State (colocation_ships_State),
    .player_turn_State      (player_turn_State),
    .pc_turn_State          (pc_turn_State),
    .is_victory_State       (is_victory_State),
    .is_defeat_State        (is_defeat_State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-hot property sampled every cycle, away from the active edge.
  always @(negedge clk) begin
    n_checks++;
    if ($countones(outs) != 1) begin
      n_errors++;
      $display("FAIL onehot t=%0t outs=%b required exactly one bit set", $time, outs);
    end
  end

  // Drive a flag pattern for one clock edge, then clear all flags.
  task automatic cyc(input logic [6:0] f);
    {ships_decided, finished_placing, finished_setUp, player_has_move,
     pc_has_move, pc_ships_zero, player_ships_zero} = f;
    @(posedge clk);
    #1;
    {ships_decided, finished_placing, finished_setUp, player_has_move,
     pc_has_move, pc_ships_zero, player_ships_zero} = F_NONE;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (outs !== O_D) begin
      n_errors++; $display("FAIL reset_state outs=%b required=%b", outs, O_D);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(F_NONE);
      n_checks++;
      if (outs !== O_D) begin
        n_errors++; $display("FAIL reset_hold[%0d] outs=%b required=%b", i, outs, O_D);
      end
    end
  endtask

  task automatic test_victory_path();
    logic [6:0] stim [7];
    logic [6:0] exp  [7];
    stim = '{F_SD, F_FP, F_FS, F_PHM, F_PCM, F_PCZ, F_PLZ};
    exp  = '{O_C,  O_S,  O_P,  O_T,   O_P,   O_V,   O_V};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(stim[i]);
      n_checks++;
      if (outs !== exp[i]) begin
        n_errors++; $display("FAIL victory_path[%0d] outs=%b required=%b", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_defeat_path();
    logic [6:0] stim [7];
    logic [6:0] exp  [7];
    stim = '{F_SD, F_FP, F_FS, F_PHM, F_PLZ, F_PCM, F_PCZ};
    exp  = '{O_C,  O_S,  O_P,  O_T,   O_F,   O_F,   O_F};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(stim[i]);
      n_checks++;
      if (outs !== exp[i]) begin
        n_errors++; $display("FAIL defeat_path[%0d] outs=%b required=%b", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_gating();
    do_reset();
    cyc(F_FP | F_FS | F_PHM | F_PCM | F_PCZ | F_PLZ);
    n_checks++;
    if (outs !== O_D) begin
      n_errors++; $display("FAIL gate_decision outs=%b required=%b", outs, O_D);
    end
    // ships_decided held for three edges reaches only COLOCATION
    for (int i = 0; i < 3; i++) begin
      cyc(F_SD);
      n_checks++;
      if (outs !== O_C) begin
        n_errors++; $display("FAIL gate_hold_sd[%0d] outs=%b required=%b", i, outs, O_C);
      end
    end
    // all placement-related flags high at once: exactly one step per edge
    cyc(F_FP | F_FS | F_PHM);
    n_checks++;
    if (outs !== O_S) begin
      n_errors++; $display("FAIL gate_chain outs=%b required=%b", outs, O_S);
    end
    cyc(F_FS);
    // pc_has_move is ignored on the player's turn
    cyc(F_PCM | F_SD);
    n_checks++;
    if (outs !== O_P) begin
      n_errors++; $display("FAIL gate_player_turn outs=%b required=%b", outs, O_P);
    end
    // player_has_move is ignored on the PC's turn
    cyc(F_PHM);
    cyc(F_PHM);
    n_checks++;
    if (outs !== O_T) begin
      n_errors++; $display("FAIL gate_pc_turn outs=%b required=%b", outs, O_T);
    end
  endtask

  task automatic test_priority();
    do_reset();
    cyc(F_SD); cyc(F_FP); cyc(F_FS);
    cyc(F_PHM | F_PCZ | F_PLZ);
    n_checks++;
    if (outs !== O_V) begin
      n_errors++; $display("FAIL prio_player_tie outs=%b required=%b", outs, O_V);
    end
    do_reset();
    cyc(F_SD); cyc(F_FP); cyc(F_FS); cyc(F_PHM);
    cyc(F_PCM | F_PLZ);
    n_checks++;
    if (outs !== O_F) begin
      n_errors++; $display("FAIL prio_pc_defeat outs=%b required=%b", outs, O_F);
    end
    do_reset();
    cyc(F_SD); cyc(F_FP); cyc(F_FS); cyc(F_PHM);
    cyc(F_PCM | F_PCZ | F_PLZ);
    n_checks++;
    if (outs !== O_V) begin
      n_errors++; $display("FAIL prio_pc_tie outs=%b required=%b", outs, O_V);
    end
    do_reset();
    cyc(F_SD); cyc(F_FP); cyc(F_FS);
    cyc(F_PHM | F_PLZ);
    n_checks++;
    if (outs !== O_F) begin
      n_errors++; $display("FAIL prio_player_defeat outs=%b required=%b", outs, O_F);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(F_SD); cyc(F_FP); cyc(F_FS); cyc(F_PHM);
    n_checks++;
    if (outs !== O_T) begin
      n_errors++; $display("FAIL async_pre outs=%b required=%b", outs, O_T);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_D) begin
      n_errors++; $display("FAIL async_immediate outs=%b required=%b", outs, O_D);
    end
    cyc(F_SD);
    n_checks++;
    if (outs !== O_D) begin
      n_errors++; $display("FAIL async_held outs=%b required=%b", outs, O_D);
    end
    rst = 1'b0;
    // reset out of a terminal state
    cyc(F_SD); cyc(F_FP); cyc(F_FS); cyc(F_PCZ);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_D) begin
      n_errors++; $display("FAIL async_terminal outs=%b required=%b", outs, O_D);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {ships_decided, finished_placing, finished_setUp, player_has_move,
     pc_has_move, pc_ships_zero, player_ships_zero} = F_NONE;
    test_reset();
    test_victory_path();
    test_defeat_path();
    test_gating();
    test_priority();
    test_async_reset();
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
